// File: rtl/count_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : count_capture_fifo
// Description : Snapshots a live count into a FIFO on qualified capture-pin
//               edges; drained and configured over a Wishbone slave port.
// Revision    : 1.0 - initial release
// ============================================================================
module count_capture_fifo #(
  parameter int BITS  = 16,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_we,
  input  logic [3:0]      wb_sel,
  input  logic [3:0]      wb_adr,
  input  logic [31:0]     wb_wdata,
  output logic            wb_ack,
  output logic [31:0]     wb_rdata,
  input  logic [BITS-1:0] count,
  input  logic            cap_in,
  output logic            irq
);

  localparam int LVLW = $clog2(DEPTH) + 1;
  localparam int AW   = $clog2(DEPTH);

  localparam logic [1:0] c_ADR_DATA   = 2'd0;
  localparam logic [1:0] c_ADR_STATUS = 2'd1;
  localparam logic [1:0] c_ADR_CTRL   = 2'd2;
  localparam logic [1:0] c_ADR_CMD    = 2'd3;

  logic [7:0]      r_ctrl;
  logic            r_sync1, r_sync2, r_hist;
  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [LVLW-1:0] r_level;
  logic            r_ovf;
  logic            r_ack;
  logic [31:0]     r_rdata;
  logic            r_irq;

  logic        w_enable, w_fall_mode, w_both, w_ovf_ie;
  logic [3:0]  w_thresh;
  logic        w_rise, w_fall, w_push;
  logic        w_req, w_pop, w_ctrl_wr, w_cmd_wr, w_flush, w_ovf_clr;
  logic        w_empty, w_full, w_push_ok, w_ovf_set, w_irq_next;
  logic [1:0]  w_reg;
  logic [31:0] w_rd_val;
  logic        w_unused;

  assign w_enable    = r_ctrl[0];
  assign w_fall_mode = r_ctrl[1];
  assign w_both      = r_ctrl[2];
  assign w_ovf_ie    = r_ctrl[3];
  assign w_thresh    = r_ctrl[7:4];

  // Edge detect between the synchronised pin and its one-cycle history
  assign w_rise = r_sync2 & ~r_hist;
  assign w_fall = ~r_sync2 & r_hist;
  assign w_push = w_enable & (w_both ? (w_rise | w_fall) : (w_fall_mode ? w_fall : w_rise));

  assign w_reg     = wb_adr[3:2];
  assign w_req     = wb_valid & ~r_ack;
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVLW'(DEPTH));
  assign w_pop     = w_req & ~wb_we & (w_reg == c_ADR_DATA) & ~w_empty;
  assign w_ctrl_wr = w_req & wb_we & (w_reg == c_ADR_CTRL) & wb_sel[0];
  assign w_cmd_wr  = w_req & wb_we & (w_reg == c_ADR_CMD);
  assign w_flush   = w_cmd_wr & wb_wdata[0];
  assign w_ovf_clr = w_cmd_wr & wb_wdata[1];

  // A pop on the same edge frees the slot, so a push at full still lands
  assign w_push_ok = w_push & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_push & ~w_flush & w_full & ~w_pop;

  assign w_irq_next = ((w_thresh != 4'd0) && (8'(r_level) >= 8'(w_thresh))) ||
                      (w_ovf_ie && r_ovf);

  assign w_unused = ^{wb_adr[1:0], wb_sel[3:1], wb_wdata[31:8]};

  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      c_ADR_DATA:   w_rd_val = w_empty ? 32'd0 : 32'(r_mem[r_rptr]);
      c_ADR_STATUS: begin
        w_rd_val[LVLW-1:0] = r_level;
        w_rd_val[8]        = w_empty;
        w_rd_val[9]        = w_full;
        w_rd_val[10]       = r_ovf;
      end
      c_ADR_CTRL:   w_rd_val = {24'd0, r_ctrl};
      c_ADR_CMD:    w_rd_val = '0;
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= cap_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_ctrl  <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) begin
        r_rdata <= w_rd_val;
      end
      if (w_ctrl_wr) begin
        r_ctrl <= wb_wdata[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push_ok && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push_ok && w_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  // A drop on the same edge as a clear leaves the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      r_irq <= w_irq_next;
    end
  end

  assign wb_ack   = r_ack;
  assign wb_rdata = r_rdata;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_count_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_capture_fifo
// Description : Directed bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_capture_fifo;

  localparam int BITS  = 16;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_valid, wb_we;
  logic [3:0]      wb_sel, wb_adr;
  logic [31:0]     wb_wdata;
  logic            wb_ack;
  logic [31:0]     wb_rdata;
  logic [BITS-1:0] count;
  logic            cap_in;
  logic            irq;

  always #5 clk = ~clk;

  count_capture_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_sel   (wb_sel),
    .wb_adr   (wb_adr),
    .wb_wdata (wb_wdata),
    .wb_ack   (wb_ack),
    .wb_rdata (wb_rdata),
    .count    (count),
    .cap_in   (cap_in),
    .irq      (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, pin samples at the last three edges
  int unsigned q[$];
  logic        m_ovf = 1'b0;
  logic [7:0]  m_ctrl = 8'd0;
  logic        m_ack = 1'b0;
  logic        m_rd_chk = 1'b0;
  logic        m_irq = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [2:0]  m_pin = 3'd0;

  always @(posedge clk) begin : model
    int          lvl;
    bit          rise, fall, push, req, popped, was_full, flush, clr, irq_n;
    logic [31:0] rd;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_ctrl = 8'd0; m_ack = 1'b0; m_rd_chk = 1'b0;
      m_irq = 1'b0; m_rdata = 32'd0; m_pin = 3'd0;
    end else begin
      lvl      = q.size();
      irq_n    = ((m_ctrl[7:4] != 0) && (lvl >= int'(m_ctrl[7:4]))) || (m_ctrl[3] && m_ovf);
      rise     = m_pin[1] && !m_pin[2];
      fall     = !m_pin[1] && m_pin[2];
      push     = m_ctrl[0] && (m_ctrl[2] ? (rise || fall) : (m_ctrl[1] ? fall : rise));
      req      = wb_valid && !m_ack;
      was_full = (lvl == DEPTH);
      popped = 0; flush = 0; clr = 0; rd = 32'd0;
      if (req) begin
        case (wb_adr[3:2])
          2'd0: if (!wb_we && lvl > 0) begin rd = q.pop_front(); popped = 1; end
          2'd1: rd = lvl + ((lvl == 0) ? 256 : 0) + (was_full ? 512 : 0) + (m_ovf ? 1024 : 0);
          2'd2: if (wb_we) begin if (wb_sel[0]) m_ctrl = wb_wdata[7:0]; end else rd = {24'd0, m_ctrl};
          default: if (wb_we) begin flush = wb_wdata[0]; clr = wb_wdata[1]; end
        endcase
      end
      if (clr) m_ovf = 1'b0;
      if (flush) q.delete();
      else if (push) begin
        if (!was_full || popped) q.push_back(count);
        else m_ovf = 1'b1;
      end
      m_ack    = req;
      m_rd_chk = req && !wb_we;
      if (req) m_rdata = rd;
      m_irq = irq_n;
      m_pin = {m_pin[1:0], cap_in};
    end
  end

  always @(posedge clk) begin : compare
    #1;
    check("ack", {31'd0, wb_ack}, {31'd0, m_ack});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    if (m_ack && m_rd_chk) check("rdata", wb_rdata, m_rdata);
  end

  logic [31:0] r;
  int          l;

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(negedge clk);
    wb_valid = 1'b1; wb_we = we; wb_adr = adr; wb_wdata = wd; wb_sel = sel;
    lat = 0;
    repeat (8) begin
      @(posedge clk); #1;
      lat++;
      if (wb_ack) break;
    end
    if (!wb_ack) begin
      n_cmp++; n_bad++;
      $display("FAIL wb_timeout: got no ack expected ack within 8 cycles at %0t", $time);
    end
    rd = wb_rdata;
    @(negedge clk);
    wb_valid = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] d);
    logic [31:0] rr; int ll;
    wb_xfer(1'b1, adr, d, 4'hF, rr, ll);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] rr; int ll;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, rr, ll);
    check(name, rr, exp);
  endtask

  task automatic pulse(input int hi, input int lo);
    cap_in = 1'b1;
    repeat (hi) @(negedge clk);
    cap_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    reset = 1'b1; wb_valid = 1'b0; wb_we = 1'b0; wb_sel = 4'h0; wb_adr = 4'h0;
    wb_wdata = 32'd0; count = '0; cap_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_rdata", wb_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    rd_chk("rst_status", 4'h4, 32'h100);

    // basic capture
    wr(4'h8, 32'h01);
    count = 16'h1234;
    pulse(3, 4);
    rd_chk("basic_status", 4'h4, 32'h001);
    wb_xfer(1'b0, 4'h0, 32'd0, 4'hF, r, l);
    check("basic_data", r, 32'h1234);
    check("basic_latency", l, 1);
    rd_chk("basic_empty", 4'h4, 32'h100);

    // latency: pin rises before the edge where count=10
    for (int i = 0; i < 16; i++) begin
      count = 16'(i);
      if (i == 10) cap_in = 1'b1;
      @(negedge clk);
    end
    cap_in = 1'b0;
    repeat (4) @(negedge clk);
    rd_chk("lat_data", 4'h0, 32'h000C);
    check("lat_irq", {31'd0, irq}, 32'd0);

    // overflow
    wr(4'h8, 32'h09);
    for (int i = 1; i <= 9; i++) begin
      count = 16'(i);
      pulse(2, 2);
    end
    repeat (2) @(negedge clk);
    rd_chk("ovf_status", 4'h4, 32'h608);
    check("ovf_irq", {31'd0, irq}, 32'd1);
    for (int i = 1; i <= 8; i++) rd_chk("ovf_data", 4'h0, 32'(i));
    rd_chk("ovf_status_drained", 4'h4, 32'h500);
    wr(4'hC, 32'h2);
    check("ovf_irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("ovf_irq_drop", {31'd0, irq}, 32'd0);
    rd_chk("ovf_cleared", 4'h4, 32'h100);

    // edge modes
    wr(4'h8, 32'h03);
    count = 16'h0055;
    pulse(3, 4);
    rd_chk("fall_status", 4'h4, 32'h001);
    wr(4'hC, 32'h1);
    wr(4'h8, 32'h05);
    count = 16'h0066;
    pulse(3, 4);
    rd_chk("both_status", 4'h4, 32'h002);
    rd_chk("both_d0", 4'h0, 32'h66);
    rd_chk("both_d1", 4'h0, 32'h66);

    // simultaneous push/pop at full
    wr(4'h8, 32'h01);
    for (int i = 0; i < 8; i++) begin
      count = 16'(16'h10 + i);
      pulse(2, 2);
    end
    repeat (2) @(negedge clk);
    rd_chk("full_status", 4'h4, 32'h208);
    cap_in = 1'b1; count = 16'h0099;
    @(negedge clk);
    rd_chk("full_pp_data", 4'h0, 32'h10);
    cap_in = 1'b0;
    rd_chk("full_pp_status", 4'h4, 32'h208);
    for (int i = 1; i < 8; i++) rd_chk("full_pp_drain", 4'h0, 32'(32'h10 + i));
    rd_chk("full_pp_last", 4'h0, 32'h99);

    // empty read, threshold, flush
    rd_chk("empty_data", 4'h0, 32'h0);
    rd_chk("empty_status", 4'h4, 32'h100);
    wr(4'h8, 32'h31);
    for (int i = 0; i < 3; i++) begin
      count = 16'(16'h20 + i);
      pulse(2, 2);
    end
    repeat (2) @(negedge clk);
    check("thr_irq", {31'd0, irq}, 32'd1);
    rd_chk("thr_status", 4'h4, 32'h003);
    wr(4'hC, 32'h1);
    repeat (2) @(negedge clk);
    rd_chk("flush_status", 4'h4, 32'h100);
    check("flush_irq", {31'd0, irq}, 32'd0);

    // threshold above depth, and byte-select gating
    wr(4'h8, 32'h91);
    wb_xfer(1'b1, 4'h8, 32'hFF, 4'hE, r, l);
    rd_chk("ctrl_nosel", 4'h8, 32'h91);
    for (int i = 0; i < 8; i++) begin
      count = 16'(16'h40 + i);
      pulse(2, 2);
    end
    repeat (2) @(negedge clk);
    rd_chk("thr9_status", 4'h4, 32'h208);
    check("thr9_irq", {31'd0, irq}, 32'd0);

    // reset during a pending request
    @(negedge clk);
    wb_valid = 1'b1; wb_we = 1'b0; wb_adr = 4'h0; reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'd0, wb_ack}, 32'd0);
    @(negedge clk);
    wb_valid = 1'b0; reset = 1'b0;
    rd_chk("rst_mid_status", 4'h4, 32'h100);
    rd_chk("rst_mid_ctrl", 4'h8, 32'h0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
- Timestamp-capture stage placed directly downstream of the free-running/loadable count register.
- On a qualified edge of an external capture pin, snapshots the current count into a DEPTH-entry FIFO.
- The management SoC drains the FIFO over the Wishbone slave port (WB MI A).
- Raises an interrupt on a fill threshold or on overflow.

Parameters:
- BITS, 16, width of count input and of each FIFO entry (1..32).
- DEPTH, 8, FIFO entries; power of two, 2..64.
- LVLW, $clog2(DEPTH)+1, width of level counter (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  wbs_cyc_i && wbs_stb_i.
- wb_we  in  1  write enable.
- wb_sel  in  4  byte selects.
- wb_adr  in  4  byte address offset; only [3:2] decoded.
- wb_wdata  in  32  write data.
- wb_ack  out  1  one-cycle acknowledge.
- wb_rdata  out  32  read data, valid with wb_ack.
- count  in  BITS  live count value to sample.
- cap_in  in  1  asynchronous capture pin (from io_in).
- irq  out  1  level interrupt.

Behaviour:
- Reset: wb_ack=0, wb_rdata=0, irq=0, FIFO empty (level=0, pointers 0), CTRL=0, overflow=0, sync/edge flops=0.
- Register map (wb_adr[3:2]):
  - 0 DATA: read pops the head entry, zero-extended to 32 bits. Write is ignored.
  - 1 STATUS (RO): [LVLW-1:0]=level, [8]=empty, [9]=full, [10]=overflow.
  - 2 CTRL (RW, byte 0 only): [0]=enable, [1]=fall (0 rising/1 falling), [2]=both edges, [3]=ovf_ie, [7:4]=thresh.
  - 3 CMD (WO): bit0=1 flushes the FIFO; bit1=1 clears overflow. Reads return 0.
- Handshake: when wb_valid && !wb_ack, wb_ack=1 at the next edge with wb_rdata loaded. wb_ack is then forced 0 for one cycle, so back-to-back requests are acked every 2 cycles.
- Side effects (pop, CTRL write, CMD) occur on the same edge that sets wb_ack, exactly once per transaction.
- CTRL is written only when wb_we && wb_sel[0].
- DATA read when empty: returns 0, no pointer change, no flag change.
- Capture path:
  - cap_in passes through a 2-flop synchroniser, then a history flop.
  - An edge is detected when sync2 != hist and matches the CTRL edge mode, and enable=1.
  - If cap_in changes before edge E0, the FIFO write happens at edge E2 and stores the value of count sampled at E2. Level reflects the new entry after E2.
  - Pulses shorter than one clk period may be missed; this is not an error.
- Push/pop rules:
  - Push and pop on the same edge: both occur, level unchanged. This holds even when full.
  - Push while full with no pop: sample dropped, overflow=1 (sticky). FIFO contents untouched.
  - Pop and push at level 0: the read returns 0 (empty), push proceeds, level becomes 1.
- Flush: pointers and level go to 0 at the ack edge. A push on that same edge is discarded. Overflow is unaffected unless CMD bit1 is also set.
- Clearing enable mid-stream stops new captures; stored entries remain readable.
- irq, registered:
  - irq = ((thresh!=0) && (level >= thresh)) || (ovf_ie && overflow).
  - Updates one cycle after level/overflow change.
  - thresh > DEPTH never fires the threshold term.
- Pointers wrap modulo DEPTH. Level saturates at DEPTH and never exceeds it.
- Reset asserted mid-transaction: pending ack is dropped, FIFO is emptied, no pop is counted.

Test Plan:
- Basic capture:
  - CTRL=0x01; hold count=0x1234; pulse cap_in high for 3 cycles.
  - Expect exactly one entry; STATUS level=1, empty=0.
  - DATA read returns 0x00001234 with ack 1 cycle after valid; STATUS then reads empty=1.
- Latency:
  - count increments every cycle from 0; cap_in rises before edge 10 (E0).
  - Stored value = count at E2 (0x000C); irq stays 0 with thresh=0.
- Overflow:
  - DEPTH=8, CTRL=0x09; generate 9 rising edges with distinct counts 1..9.
  - level=8, full=1, overflow=1, irq=1.
  - 8 DATA reads return 1..8 in order.
  - CMD=0x2 clears overflow and irq drops the next cycle.
- Edge modes:
  - CTRL=0x03 (falling) then 0x05 (both).
  - A 0->1->0 pulse yields 1 entry, then 2 entries respectively.
- Simultaneous push/pop at full:
  - Fill to 8; DATA read ack edge coincides with a capture edge.
  - level stays 8, overflow=0, new value appears as the last entry.
- Empty read, flush, and reset:
  - Read DATA while empty -> 0, level 0.
  - Load 3 entries, CMD=0x1 -> level=0.
  - Assert reset during a pending wb_valid -> no ack, all status fields reset.
